// File: rtl/pwr_cntr_lector.sv
// ---------------------------------------------------------------------------
// pwr_cntr_lector
//
// Initiator for the transition-counter memory port (dir / LE / dato). On a
// request it either clears every power counter to zero, or reads each
// counter in turn and streams (address, value) pairs out over valid/ready.
//
// Ports:
//   clk        : single clock, rising edge
//   reset_L    : synchronous active-low reset
//   clear_req  : one-cycle request to zero all counters (wins over read_req)
//   read_req   : one-cycle request to read out all counters
//   busy       : high while a clear or read sequence is running
//   done       : one-cycle pulse when a sequence completes
//   dir        : counter address to the memory
//   LE         : 1 = memory drives dato, 0 = this block drives dato
//   dato       : shared data bus, driven here only while LE = 0
//   out_valid  : readout word available
//   out_ready  : consumer accepts the readout word
//   out_dir    : address of the readout word
//   out_data   : counter value of the readout word
//
// Every output is a register. The outputs are computed from the next state
// so each one changes on the same edge as the state it belongs to.
// ---------------------------------------------------------------------------
module pwr_cntr_lector #(
    parameter int NUM_CNTR = 3,
    parameter int NDIR     = 1,
    parameter int DW       = 32
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            clear_req,
    input  logic            read_req,
    output logic            busy,
    output logic            done,
    output logic [NDIR:0]   dir,
    output logic            LE,
    inout  wire  [DW-1:0]   dato,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NDIR:0]   out_dir,
    output logic [DW-1:0]   out_data
);

    if ((2 ** (NDIR + 1)) < NUM_CNTR) begin : g_bad_ndir
        $error("pwr_cntr_lector: dir (NDIR+1 bits) cannot address NUM_CNTR counters");
    end

    localparam logic [NDIR:0] LAST_IDX = (NDIR + 1)'(NUM_CNTR - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR_SET,
        CLR_WR,
        CLR_REL,
        RD_SET,
        RD_SMP,
        RD_PUSH,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [NDIR:0]   idx_q, idx_d;
    logic            le_q, le_d;
    logic [NDIR:0]   dir_q, dir_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            out_valid_q, out_valid_d;
    logic [NDIR:0]   out_dir_q, out_dir_d;
    logic [DW-1:0]   out_data_q, out_data_d;

    // The only value ever written is zero; the enable comes straight from
    // the LE register so driver and LE can never disagree.
    assign dato      = le_q ? {DW{1'bz}} : {DW{1'b0}};
    assign LE        = le_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_dir   = out_dir_q;
    assign out_data  = out_data_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLR_SET;
                    idx_d   = '0;
                end else if (read_req) begin
                    state_d = RD_SET;
                    idx_d   = '0;
                end
            end
            CLR_SET: state_d = CLR_WR;
            CLR_WR:  state_d = CLR_REL;
            CLR_REL: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = CLR_SET;
                    idx_d   = idx_q + 1'b1;
                end
            end
            RD_SET: state_d = RD_SMP;
            RD_SMP: state_d = RD_PUSH;
            RD_PUSH: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_SET;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered outputs derived from the state being entered. dir only
        // moves on CLR_SET/RD_SET entry or on leaving a sequence, and LE only
        // toggles around CLR_WR, so the two never change on the same edge.
        le_d        = (state_d != CLR_WR);
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);
        dir_d       = busy_d ? idx_d : '0;
        out_valid_d = (state_d == RD_PUSH);

        // The readout word is captured as RD_SMP exits and held through the
        // whole RD_PUSH stall; IDLE returns it to zero.
        out_dir_d  = out_dir_q;
        out_data_d = out_data_q;
        if (state_q == RD_SMP) begin
            out_dir_d  = idx_q;
            out_data_d = dato;
        end else if (state_d == IDLE) begin
            out_dir_d  = '0;
            out_data_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            le_q        <= 1'b1;
            dir_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_dir_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            le_q        <= le_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_dir_q   <= out_dir_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_pwr_cntr_lector.sv
// ---------------------------------------------------------------------------
// tb_pwr_cntr_lector
//
// Bench for pwr_cntr_lector with a level-sensitive counter memory model.
// Expected readout words go into a scoreboard queue when a read is issued;
// a separate monitor pops and compares on every handshake. Bus behaviour is
// collected per cycle over a fixed window after each request.
// ---------------------------------------------------------------------------
module tb_pwr_cntr_lector;

    localparam int NUM_CNTR = 3;
    localparam int NDIR     = 1;
    localparam int DW       = 32;

    typedef struct packed {
        logic [NDIR:0] d;
        logic [DW-1:0] v;
    } word_t;

    logic            clk = 1'b0;
    logic            reset_L;
    logic            clear_req;
    logic            read_req;
    logic            busy;
    logic            done;
    logic [NDIR:0]   dir;
    logic            LE;
    wire  [DW-1:0]   dato;
    logic            out_valid;
    logic            out_ready;
    logic [NDIR:0]   out_dir;
    logic [DW-1:0]   out_data;

    logic [DW-1:0]   mem [NUM_CNTR];
    word_t           sb_q [$];

    int n_pass  = 0;
    int n_total = 0;

    // Per-window statistics.
    int busy_cnt, le_low_cnt, done_cnt, valid_cnt;
    int first_valid, last_valid, done_idx;
    int bus_viol, hold_bad, dato_bad, lelow_dir_bad;

    pwr_cntr_lector #(.NUM_CNTR(NUM_CNTR), .NDIR(NDIR), .DW(DW)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .clear_req (clear_req),
        .read_req  (read_req),
        .busy      (busy),
        .done      (done),
        .dir       (dir),
        .LE        (LE),
        .dato      (dato),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dir   (out_dir),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Memory: drives the bus while LE=1, captures the bus while LE=0.
    assign dato = LE ? mem[dir] : {DW{1'bz}};
    always @(posedge clk) begin
        if (!LE) mem[dir] <= dato;
    end

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: a word is consumed when valid and ready are both
    // high at the falling edge, i.e. just before the handshaking edge.
    always @(negedge clk) begin
        if (reset_L && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word_dir", {30'd0, out_dir}, 32'hFFFF_FFFF);
            end else begin
                word_t w;
                w = sb_q.pop_front();
                check("sb_out_dir", {30'd0, out_dir}, {30'd0, w.d});
                check("sb_out_data", out_data, w.v);
            end
        end
    end

    task automatic pulse_req(input logic c, input logic r);
        clear_req = c;
        read_req  = r;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        read_req  = 1'b0;
    endtask

    // Observe ncyc cycles following the accepting edge (index 0 = the cycle
    // right after it). out_ready is low for indices rdy_lo..rdy_hi; read_req
    // is pulsed during index inj_a and inj_b (-1 = none); reset is asserted
    // during index rst_at (-1 = none).
    task automatic run_window(input int ncyc, input int rdy_lo, input int rdy_hi,
                              input int inj_a, input int inj_b, input int rst_at);
        logic          prev_le;
        logic [NDIR:0] prev_dir;
        busy_cnt = 0; le_low_cnt = 0; done_cnt = 0; valid_cnt = 0;
        first_valid = -1; last_valid = -1; done_idx = -1;
        bus_viol = 0; hold_bad = 0; dato_bad = 0; lelow_dir_bad = 0;
        prev_le = LE;
        prev_dir = dir;
        for (int i = 0; i < ncyc; i++) begin
            out_ready = !(i >= rdy_lo && i <= rdy_hi);
            read_req  = (i == inj_a) || (i == inj_b);
            if (i == rst_at) reset_L = 1'b0;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_idx = i;
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = i;
                last_valid = i;
            end
            if (!LE) begin
                if (dir != le_low_cnt[NDIR:0]) lelow_dir_bad++;
                if (dato !== '0) dato_bad++;
                le_low_cnt++;
            end
            if ((LE != prev_le) && (dir != prev_dir)) bus_viol++;
            if (i >= rdy_lo && i <= rdy_hi &&
                !(out_valid && out_dir == 2'd1 && out_data == 32'd20 && dir == 2'd1))
                hold_bad++;
            prev_le  = LE;
            prev_dir = dir;
            @(posedge clk);
            #1;
            read_req = 1'b0;
            reset_L  = 1'b1;
        end
        out_ready = 1'b1;
    endtask

    task automatic load_mem(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c);
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
    endtask

    initial begin
        reset_L   = 1'b0;
        clear_req = 1'b0;
        read_req  = 1'b0;
        out_ready = 1'b1;
        load_mem($urandom, $urandom, $urandom);

        // Reset with random request/handshake history on the inputs.
        for (int i = 0; i < 2; i++) begin
            clear_req = 1'($urandom);
            read_req  = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        clear_req = 1'b0;
        read_req  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_LE", {31'd0, LE}, 32'd1);
        check("rst_dir", {30'd0, dir}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_dir_data", {30'd0, out_dir} | out_data, 32'd0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        @(posedge clk);
        #1;

        // Clear: 5, 7, 9 -> 0, 0, 0.
        load_mem(32'd5, 32'd7, 32'd9);
        pulse_req(1'b1, 1'b0);
        run_window(14, 99, 99, -1, -1, -1);
        check("clr_busy_cycles", busy_cnt, 32'd9);
        check("clr_le_low_cycles", le_low_cnt, 32'd3);
        check("clr_le_low_dir", lelow_dir_bad, 32'd0);
        check("clr_dato_zero", dato_bad, 32'd0);
        check("clr_done_pulses", done_cnt, 32'd1);
        check("clr_bus_rule", bus_viol, 32'd0);
        check("clr_no_valid", valid_cnt, 32'd0);
        check("clr_mem0", mem[0], 32'd0);
        check("clr_mem1", mem[1], 32'd0);
        check("clr_mem2", mem[2], 32'd0);

        // Read, no backpressure.
        load_mem(32'd10, 32'd20, 32'd30);
        sb_q.push_back('{d: 2'd0, v: 32'd10});
        sb_q.push_back('{d: 2'd1, v: 32'd20});
        sb_q.push_back('{d: 2'd2, v: 32'd30});
        pulse_req(1'b0, 1'b1);
        run_window(14, 99, 99, -1, -1, -1);
        check("rd_first_valid_idx", first_valid, 32'd2);
        check("rd_valid_cycles", valid_cnt, 32'd3);
        check("rd_done_after_last", done_idx, 32'(last_valid + 1));
        check("rd_done_pulses", done_cnt, 32'd1);
        check("rd_le_never_low", le_low_cnt, 32'd0);
        check("rd_sb_empty", sb_q.size(), 32'd0);
        check("rd_idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure on word (1,20) for 5 cycles.
        sb_q.push_back('{d: 2'd0, v: 32'd10});
        sb_q.push_back('{d: 2'd1, v: 32'd20});
        sb_q.push_back('{d: 2'd2, v: 32'd30});
        pulse_req(1'b0, 1'b1);
        run_window(18, 5, 9, -1, -1, -1);
        check("bp_hold", hold_bad, 32'd0);
        check("bp_valid_cycles", valid_cnt, 32'd8);
        check("bp_done_idx", done_idx, 32'd14);
        check("bp_done_pulses", done_cnt, 32'd1);
        check("bp_sb_empty", sb_q.size(), 32'd0);

        // Arbitration: both requests together, then read_req mid-clear and
        // while in DONE.
        load_mem(32'd1, 32'd2, 32'd3);
        pulse_req(1'b1, 1'b1);
        run_window(16, 99, 99, 4, 9, -1);
        check("arb_busy_cycles", busy_cnt, 32'd9);
        check("arb_le_low_cycles", le_low_cnt, 32'd3);
        check("arb_no_valid", valid_cnt, 32'd0);
        check("arb_done_pulses", done_cnt, 32'd1);
        check("arb_mem_cleared", mem[0] | mem[1] | mem[2], 32'd0);

        // Reset during CLR_SET for counter 1.
        load_mem(32'd5, 32'd7, 32'd9);
        pulse_req(1'b1, 1'b0);
        run_window(4, 99, 99, -1, -1, 3);
        @(negedge clk);
        check("mrst_LE", {31'd0, LE}, 32'd1);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_dir", {30'd0, dir}, 32'd0);
        check("mrst_mem0", mem[0], 32'd0);
        check("mrst_mem1", mem[1], 32'd7);
        check("mrst_mem2", mem[2], 32'd9);
        @(posedge clk);
        #1;
        sb_q.push_back('{d: 2'd0, v: 32'd0});
        sb_q.push_back('{d: 2'd1, v: 32'd7});
        sb_q.push_back('{d: 2'd2, v: 32'd9});
        pulse_req(1'b0, 1'b1);
        run_window(14, 99, 99, -1, -1, -1);
        check("mrst_rd_done", done_cnt, 32'd1);
        check("mrst_sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwr_cntr_lector.md
Name: pwr_cntr_lector

Overview:
- Synthesizable initiator for the transition-counter memory port (dir / LE / dato).
- On request it either clears every power counter to zero, or reads every counter in turn and streams each (address, value) pair out over a valid/ready interface.
- Replaces the hand-sequenced clear and readout loops in the adder power-analysis benches, so the same sequence can be reused across all bench variants.

Parameters:
- NUM_CNTR, 3, number of transition counters; addresses 0..NUM_CNTR-1.
- NDIR, 1, address MSB; dir is NDIR+1 bits wide. Elaboration fails unless 2^(NDIR+1) >= NUM_CNTR.
- DW, 32, counter data width.

Ports:
- clk  input  1  single clock, rising edge.
- reset_L  input  1  synchronous, active-low reset.
- clear_req  input  1  one-cycle request to zero all counters.
- read_req  input  1  one-cycle request to read out all counters.
- busy  output  1  high while a clear or read sequence is running.
- done  output  1  one-cycle pulse when a sequence completes.
- dir  output  NDIR+1  counter address to the memory.
- LE  output  1  1 = memory drives dato (read); 0 = this block drives dato (write).
- dato  inout  DW  shared data bus; driven by this block only while LE=0, otherwise high-Z.
- out_valid  output  1  readout word available.
- out_ready  input  1  consumer accepts the word.
- out_dir  output  NDIR+1  address of the readout word.
- out_data  output  DW  counter value of the readout word.

Behaviour:
- All outputs are registered. The dato drive enable equals ~LE, taken from the same register.
- Reset, and the values held in IDLE:
  - LE=1, dato=Z, dir=0.
  - busy=0, done=0, out_valid=0, out_dir=0, out_data=0.
- Bus safety rules (the memory is level-sensitive on dir and LE):
  - dir never changes on the same edge that LE changes.
  - dato is driven only while LE=0.
- States: IDLE, CLR_SET, CLR_WR, CLR_REL, RD_SET, RD_SMP, RD_PUSH, DONE.
- IDLE:
  - clear_req=1 -> CLR_SET with i=0.
  - else read_req=1 -> RD_SET with i=0.
  - Both high in the same cycle: clear wins; the read is dropped.
- Request acceptance:
  - Requests are accepted only in IDLE.
  - Requests arriving in any other state, including DONE, are ignored and not queued.
- Clear sequence, per counter i:
  - CLR_SET: dir=i, LE=1.
  - CLR_WR: LE=0, dato=0.
  - CLR_REL: LE=1, dato=Z.
  - From CLR_REL: if i==NUM_CNTR-1 -> DONE, else i+1 -> CLR_SET.
  - A full clear takes 3*NUM_CNTR cycles with busy=1.
- Read sequence, per counter i:
  - RD_SET: dir=i, LE=1.
  - RD_SMP: one settle cycle; out_data<=dato and out_dir<=i on exit.
  - RD_PUSH: out_valid=1; out_dir and out_data are held stable until out_ready=1.
  - On the edge with out_valid && out_ready: out_valid<=0; if i==NUM_CNTR-1 -> DONE, else i+1 -> RD_SET.
  - LE stays 1 for the whole read sequence.
- Read latency: request accepted at edge k -> out_valid high from edge k+2. With out_ready tied high, each counter costs 3 cycles.
- DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- Synchronous reset mid-sequence:
  - Next edge returns to IDLE with LE=1 and dato released; any pending out_valid is dropped.
  - Counters already written stay zero; unwritten counters are unchanged.
- Address wrap: the address never exceeds NUM_CNTR-1. The index register is NDIR+1 bits and the terminal compare is equality.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with a random bus history -> LE=1, dato=Z, dir=0, busy=0, out_valid=0, done=0.
- Clear: memory model preloaded with 5, 7, 9; pulse clear_req ->
  - busy high for 9 cycles.
  - LE low in exactly 3 single cycles, at dir=0, 1, 2 respectively, with dato=0 in each.
  - done pulses once.
  - Memory reads back 0, 0, 0.
- Read, no backpressure: memory 10, 20, 30, out_ready=1, read_req at edge k ->
  - Handshaked words (0,10), (1,20), (2,30); first out_valid at edge k+2.
  - done one cycle after the last handshake; LE never low.
- Backpressure: same setup, out_ready=0 for 5 cycles while word (1,20) is valid ->
  - out_valid, out_dir=1 and out_data=20 are held.
  - dir stays 1; no extra words appear; sequence completes after release.
- Arbitration: clear_req and read_req high in the same cycle -> clear sequence only, no out_valid. A read_req pulsed mid-clear and in DONE -> ignored.
- Reset mid-clear: assert reset_L=0 at cycle 4 of a clear (CLR_SET for i=1) -> next edge LE=1, dato=Z, IDLE. Counter 0 reads 0; counters 1 and 2 keep their old values.
